uart_tx_drain: RTL and testbench

Serial UART transmitter that drains the transmit-side FIFO and drives the TX pin. It sits between the CPU-facing transmit FIFO and the board-level `tx` pad. It pops one byte at a time through the FIFO's read interface (`q`/`empty`/`read_ack`) and emits 8N1 frames, LSB first, at a fixed bit period.

---
 rtl/uart_tx_drain_if.sv | 21 ++
 rtl/uart_tx_drain.sv | 135 +++++++++++++
 tb/tb_uart_tx_drain.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_drain_if.sv
// Read-side handshake between the transmit FIFO and the UART drain.
// The drain pulls bytes, so it takes the master role; the FIFO is the slave.
interface uart_tx_drain_if #(
  parameter int DataBitsSize = 8
);
  logic [DataBitsSize-1:0] fifo_q;
  logic                    fifo_empty;
  logic                    fifo_read_ack;

  modport master (
    input  fifo_q,
    input  fifo_empty,
    output fifo_read_ack
  );

  modport slave (
    output fifo_q,
    output fifo_empty,
    input  fifo_read_ack
  );
endinterface

// File: rtl/uart_tx_drain.sv
// 8N1 UART transmitter that pops bytes from the TX FIFO and shifts them out LSB first.
// tx/busy are registered from next-state values so they move on the same edge as the FSM.
module uart_tx_drain #(
  parameter int ClksPerBit   = 434,
  parameter int DataBitsSize = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  uart_tx_drain_if.master fifo,
  output logic            tx,
  output logic            busy
);

  localparam int BW  = $clog2(ClksPerBit);
  localparam int BCW = $clog2(DataBitsSize) + 1;
  localparam logic [BW-1:0]  BAUD_MAX = BW'(ClksPerBit - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DataBitsSize - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                  state_r, state_nx_s;
  logic [BW-1:0]           baud_r, baud_nx_s;
  logic [BCW-1:0]          bit_r, bit_nx_s;
  logic [DataBitsSize-1:0] shift_r, shift_nx_s;
  logic                    tx_r, tx_nx_s;
  logic                    busy_r, busy_nx_s;
  logic                    baud_done_s;
  logic                    take_s;

  assign baud_done_s = (baud_r == BAUD_MAX);
  // Pop is suppressed while reset is held so the FIFO never loses a byte to a dead DUT.
  assign take_s = rst_n & enable & ~fifo.fifo_empty &
                  ((state_r == IDLE) | ((state_r == STOP) & baud_done_s));

  assign fifo.fifo_read_ack = take_s;
  assign tx                 = tx_r;
  assign busy               = busy_r;

  // Next-state, counter, shifter and output decode.
  always_comb begin
    state_nx_s = state_r;
    baud_nx_s  = baud_r;
    bit_nx_s   = bit_r;
    shift_nx_s = shift_r;
    tx_nx_s    = 1'b1;
    busy_nx_s  = 1'b0;

    case (state_r)
      IDLE: begin
        baud_nx_s = {BW{1'b0}};
        if (take_s) begin
          shift_nx_s = fifo.fifo_q;
          state_nx_s = START;
        end else begin
          state_nx_s = IDLE;
        end
      end
      START: begin
        if (baud_done_s) begin
          baud_nx_s  = {BW{1'b0}};
          bit_nx_s   = {BCW{1'b0}};
          state_nx_s = DATA;
        end else begin
          baud_nx_s = baud_r + BW'(1);
        end
      end
      DATA: begin
        if (baud_done_s) begin
          baud_nx_s  = {BW{1'b0}};
          shift_nx_s = shift_r >> 1;
          bit_nx_s   = bit_r + BCW'(1);
          if (bit_r == BIT_LAST) begin
            state_nx_s = STOP;
          end else begin
            state_nx_s = DATA;
          end
        end else begin
          baud_nx_s = baud_r + BW'(1);
        end
      end
      STOP: begin
        if (baud_done_s) begin
          baud_nx_s = {BW{1'b0}};
          if (take_s) begin
            shift_nx_s = fifo.fifo_q;
            state_nx_s = START;
          end else begin
            state_nx_s = IDLE;
          end
        end else begin
          baud_nx_s = baud_r + BW'(1);
        end
      end
      default: begin
        state_nx_s = IDLE;
        baud_nx_s  = {BW{1'b0}};
      end
    endcase

    case (state_nx_s)
      IDLE:    tx_nx_s = 1'b1;
      START:   tx_nx_s = 1'b0;
      DATA:    tx_nx_s = shift_nx_s[0];
      STOP:    tx_nx_s = 1'b1;
      default: tx_nx_s = 1'b1;
    endcase
    busy_nx_s = (state_nx_s != IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      baud_r  <= {BW{1'b0}};
      bit_r   <= {BCW{1'b0}};
      shift_r <= {DataBitsSize{1'b0}};
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      baud_r  <= baud_nx_s;
      bit_r   <= bit_nx_s;
      shift_r <= shift_nx_s;
      tx_r    <= tx_nx_s;
      busy_r  <= busy_nx_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain: a small FIFO model feeds bytes, a scoreboard queue
// holds the bytes expected on the line, and a line monitor rebuilds every frame.
module tb_uart_tx_drain;

  localparam int CPB   = 4;
  localparam int DB    = 8;
  localparam int FRAME = (DB + 2) * CPB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic tx, busy;
  logic ovr_en = 1'b0;
  logic [7:0] ovr_v = 8'h00;

  logic [7:0] mem [0:15];
  logic [3:0] wr_ptr = 4'd0;
  logic [3:0] rd_ptr = 4'd0;
  logic [7:0] exp_q[$];

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int npop = 0;
  int npush = 0;
  int nframes = 0;
  int nsamp = 0;
  int start_cyc = 0;
  int start_prev = 0;
  int pop_cyc = 0;
  int pop_prev = 0;
  bit in_frame = 1'b0;
  logic ack_s = 1'b0;
  logic [FRAME-1:0] wave, bzv;

  uart_tx_drain_if #(.DataBitsSize(DB)) ff ();

  uart_tx_drain #(.ClksPerBit(CPB), .DataBitsSize(DB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .fifo   (ff),
    .tx     (tx),
    .busy   (busy)
  );

  assign ff.fifo_empty = (wr_ptr == rd_ptr);
  assign ff.fifo_q     = ovr_en ? ovr_v : mem[rd_ptr];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 4'd1;
    exp_q.push_back(b);
    npush++;
  endtask

  task automatic wait_drain(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !in_frame && busy === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    chk(tag, done, 1'b1);
  endtask

  task automatic wait_samp(input int n, input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (in_frame && nsamp >= n) begin
        done = 1'b1;
        break;
      end
    end
    chk(tag, done, 1'b1);
  endtask

  // FIFO model: pop on the edge where the DUT strobed read_ack.
  always @(posedge clk) begin
    if (ack_s) rd_ptr <= rd_ptr + 4'd1;
  end

  // Line monitor: samples away from the active edge and checks each frame against the scoreboard.
  always @(negedge clk) begin
    logic [7:0] e;
    logic [FRAME-1:0] ew;
    int idx;
    cyc++;
    ack_s = ff.fifo_read_ack;
    chk("ack_when_empty", ff.fifo_read_ack & ff.fifo_empty, 1'b0);
    if (ack_s) begin
      npop++;
      pop_prev = pop_cyc;
      pop_cyc = cyc;
    end
    if (!rst_n) begin
      if (in_frame) begin
        void'(exp_q.pop_front());
        in_frame = 1'b0;
      end
    end else begin
      if (!in_frame && tx === 1'b0) begin
        in_frame = 1'b1;
        nsamp = 0;
        start_prev = start_cyc;
        start_cyc = cyc;
      end
      if (in_frame) begin
        wave[nsamp] = tx;
        bzv[nsamp] = busy;
        nsamp++;
        if (nsamp == FRAME) begin
          in_frame = 1'b0;
          nframes++;
          if (exp_q.size() == 0) begin
            chk("frame_unexpected", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            for (int i = 0; i < FRAME; i++) begin
              idx = i / CPB;
              if (idx == 0) ew[i] = 1'b0;
              else if (idx == DB + 1) ew[i] = 1'b1;
              else ew[i] = e[idx-1];
            end
            chk("frame_wave", wave, ew);
            chk("frame_busy", bzv, {FRAME{1'b1}});
          end
        end
      end
    end
  end

  initial begin
    int p0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", {tx, busy, ff.fifo_read_ack}, 3'b100);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {tx, busy}, 2'b10);

    // Empty FIFO with enable high: line stays idle
    @(posedge clk); #1 enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("empty_idle", {tx, busy, ff.fifo_read_ack}, 3'b100);
    end

    // Single byte 0xA5 with start latency
    p0 = npop;
    @(posedge clk); #1 push(8'hA5);
    @(negedge clk);
    chk("pop_same_cycle", {ff.fifo_read_ack, tx}, 2'b11);
    @(negedge clk);
    chk("start_latency", {tx, busy}, 2'b01);
    wait_drain("drain_a5");
    chk("a5_pops", npop - p0, 1);
    chk("a5_idle_after", {tx, busy}, 2'b10);

    // Back-to-back 0x00 then 0xFF
    p0 = npop;
    @(posedge clk); #1 push(8'h00); push(8'hFF);
    wait_drain("drain_b2b");
    chk("b2b_pops", npop - p0, 2);
    chk("b2b_pop_spacing", pop_cyc - pop_prev, FRAME);
    chk("b2b_start_spacing", start_cyc - start_prev, FRAME);

    // Enable drop during data bit 3 of 0x3C with 0x55 queued
    @(posedge clk); #1 push(8'h3C); push(8'h55);
    wait_samp(4 * CPB + 1, "reach_bit3");
    @(posedge clk); #1 enable = 1'b0;
    p0 = npop;
    for (int i = 0; i < 80; i++) @(negedge clk);
    chk("en_drop_no_pop", npop - p0, 0);
    chk("en_drop_idle", {tx, busy}, 2'b10);
    chk("en_drop_queue", exp_q.size(), 1);
    @(posedge clk); #1 enable = 1'b1;
    @(negedge clk);
    chk("reenable_pop", ff.fifo_read_ack, 1'b1);
    wait_drain("drain_55");

    // Reset mid-frame during DATA; 0x96 is lost, 0x4B follows intact
    @(posedge clk); #1 push(8'h96); push(8'h4B);
    wait_samp(2 * CPB + 2, "reach_data");
    @(posedge clk); #1 rst_n = 1'b0;
    #1 chk("async_reset", {tx, busy, ff.fifo_read_ack}, 3'b100);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_drain("drain_4b");

    // Head change after pop of 0x81
    @(posedge clk); #1 push(8'h81);
    @(negedge clk);
    chk("pop_81", ff.fifo_read_ack, 1'b1);
    @(posedge clk); #1 ovr_v = 8'h00; ovr_en = 1'b1;
    wait_drain("drain_81");
    ovr_en = 1'b0;

    chk("total_pops", npop, npush);
    chk("total_frames", nframes, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
